mux4_rr_arbiter: RTL

Round-robin arbiter and sequencer for the shared 4:1 mux datapath. Four requesters compete for one output channel. The block picks one requester, drives the mux select, and routes that requester's data and valid/ready handshake to the output. It holds the grant until a packet completes, which is signalled by `last` on an accepted beat. It sits directly in front of `mux4x1_struct`-style datapaths and replaces a free-running or testbench-driven `Sel`.

---
 rtl/mux4_pkg.sv | 31 +++
 rtl/rr_pick4.sv | 25 ++
 rtl/mux4_rr_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/mux4_pkg.sv
// Shared definitions for the 4:1 mux datapath and its round-robin arbiter.
// Holds the requester count, the select encodings and the arbiter state type.
package mux4_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   localparam logic [SEL_W-1:0] SEL_A = 2'd0;
   localparam logic [SEL_W-1:0] SEL_B = 2'd1;
   localparam logic [SEL_W-1:0] SEL_C = 2'd2;
   localparam logic [SEL_W-1:0] SEL_D = 2'd3;

   // Convert a mux select into the matching one-hot grant vector.
   function automatic logic [NUM_REQ-1:0] sel_to_grant(input logic [SEL_W-1:0] s);
      logic [NUM_REQ-1:0] g;
      case (s)
         SEL_A:   g = 4'b0001;
         SEL_B:   g = 4'b0010;
         SEL_C:   g = 4'b0100;
         SEL_D:   g = 4'b1000;
         default: g = 4'b0000;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: returns the first set request
// found when searching upward (mod 4) starting at ptr.
module rr_pick4
   import mux4_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               found,
   output logic [SEL_W-1:0]   idx
);

   // Walk from the farthest offset back to ptr so the nearest hit overwrites.
   // NOTE: idx gets a default before the loop so no path leaves it unassigned,
   // which is what keeps a combinational block from inferring a latch.
   always_comb begin
      found = |req;
      idx   = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[ptr + SEL_W'(k)]) begin
            idx = ptr + SEL_W'(k);
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux: grants one requester per packet,
// drives sel, and steers that requester's data and handshake to the output.
module mux4_rr_arbiter
   import mux4_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   input  logic                      out_ready,
   output logic [SEL_W-1:0]          sel,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy
);

   arb_state_e         state_q;
   arb_state_e         state_d;
   logic [SEL_W-1:0]   ptr;
   logic               pick_found;
   logic [SEL_W-1:0]   pick_idx;
   logic               pkt_done;

   rr_pick4 u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign pkt_done = (state_q == ARB_BUSY) & out_valid & out_ready & out_last;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: if (pick_found) state_d = ARB_BUSY;
         ARB_BUSY: if (pkt_done)   state_d = ARB_IDLE;
         default:                  state_d = ARB_IDLE;
      endcase
   end

   // Grant registers; ptr moves only on packet completion, never on a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= SEL_A;
         sel   <= SEL_A;
         grant <= '0;
         busy  <= 1'b0;
      end else if (state_q == ARB_IDLE && pick_found) begin
         sel   <= pick_idx;
         grant <= sel_to_grant(pick_idx);
         busy  <= 1'b1;
      end else if (pkt_done) begin
         ptr   <= sel + 1'b1;
         grant <= '0;
         busy  <= 1'b0;
      end
   end

   // Steering is purely combinational from the registered sel.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      req_ready = '0;
      if (state_q == ARB_BUSY) begin
         out_valid      = req_valid[sel];
         out_data       = req_data[int'(sel)*DATA_W +: DATA_W];
         out_last       = req_last[sel];
         req_ready[sel] = out_ready;
      end
   end

   a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
   a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
   a_busy_grant   : assert property (@(posedge clk) disable iff (!rst_n) busy == (grant != '0));

endmodule
